times_table_gen: RTL
====================

# times_table_gen

Parametrised successor to the fixed 3-bit times-table lookup. After reset the block builds its own product table in internal RAM by repeated addition, with no pre-initialised memory. It then serves pipelined lookups of a×b with a request/valid handshake. It sits where the fixed-table lookup sits, and feeds any consumer that needs a registered small-operand product.

## Interface
- W, default 3: operand width in bits. Table depth N = 2^(2W); result width 2W.
- clk  in  1: sole clock, rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- a  in  W: multiplicand, sampled with req.
- b  in  W: multiplier, sampled with req.
- req  in  1: lookup request; accepted only on an edge where ready=1.
- rebuild  in  1: request to recompute the table; acted on only in SERVE.
- ready  out  1: high in SERVE, low in FILL and during reset.
- valid  out  1: one-cycle pulse per accepted request.
- result  out  2W: product a×b; holds its value between valid pulses.

## Operation
- Internal RAM: N entries × 2W bits, address {a,b} with a in the MSBs, synchronous read and write.
- State machine has two states, FILL and SERVE. Reset state is FILL.
- FILL:
  - Index counter idx runs from 0 to N-1, one per clock. a_i = idx[2W-1:W], b_i = idx[W-1:0].
  - Accumulator prod (2W bits) gives the value written at idx:
    - when b_i = 0, prod = 0;
    - otherwise prod = previous prod + a_i.
  - The block contains no multiplier. Maximum value is (2^W-1)^2, which fits in 2W bits, so no overflow handling is needed.
  - Entry idx is written every cycle.
  - After idx = N-1 is written, idx wraps to 0 and the state becomes SERVE.
- SERVE:
  - ready = 1.
  - req=1 at an edge: RAM read of {a,b} is issued, and a stage-1 valid bit is set.
  - Next edge: result <= read data, valid <= stage-1 bit.
  - One request can be accepted per cycle, so back-to-back streaming is supported.
- rebuild=1 in SERVE:
  - State goes to FILL at that edge, with idx=0.
  - A req on the same edge is still accepted and served normally, because its read happens before the first FILL write.
  - Requests already in flight drain and their valid pulses still occur.
- req while ready=0 is ignored. No valid pulse results and nothing is queued.
- rebuild in FILL is ignored. The current fill continues; it does not restart.
- Reset values: ready=0, valid=0, result=0, stage-1 valid=0, idx=0, prod=0, state=FILL.
  - RAM contents are not reset; they are overwritten by the fill.
- Reset asserted mid-fill or mid-lookup:
  - All outputs go to their reset values immediately, without waiting for a clock.
  - In-flight lookups are discarded.
  - The fill restarts from idx=0 after release.

## Timing
- Fill:
  - Starts at the first rising edge after rst_n rises; entry 0 is written at that edge (edge 1).
  - Entry N-1 is written at edge N; ready goes high after edge N. For W=3 that is 64 edges.
- Lookup latency:
  - req accepted at edge E; valid=1 and result valid after edge E+1, i.e. two cycles from request to visible data.
  - valid drops after edge E+2 unless another request was accepted at E+1.
- Rebuild:
  - rebuild at edge R: ready=0 after R.
  - Entry 0 is written at R+1; ready returns after edge R+N.
- Asynchronous reset is asserted immediately. Release is assumed to be synchronised externally to clk.

## Test plan
- Reset fill, W=3: release rst_n and count edges until ready -> ready=0 for edges 1..63 and 1 after edge 64. Valid stays 0 throughout.
- Single lookup, W=3: a=7, b=6, req for one cycle at edge E -> valid=1 and result=42 after E+1; result still 42 and valid=0 after E+2.
- Full table sweep, W=3: stream all 64 {a,b} pairs back-to-back -> 64 consecutive valid pulses, each result equal to a×b, including 0×7=0 and 7×7=49.
- Request during FILL: hold req=1 with a=3, b=3 from reset release -> no valid pulse before ready rises. After ready, the first valid gives result=9.
- Rebuild with simultaneous request: in SERVE, assert rebuild and req (a=5, b=5) on the same edge -> result=25 with valid two cycles later. ready is low for 64 cycles, then lookup 6×7 returns 42.
- Reset mid-fill plus wider operands, W=4: pull rst_n low at fill edge 100 -> outputs 0 immediately. After release, ready rises only after 256 edges, and lookup 15×15 returns 225.

Source files
------------

// File: rtl/times_table_if.sv
// -----------------------------------------------------------------------------
// times_table_if
//   Lookup bus of the times-table generator.
//
//   Parameter
//     W        operand width; result width is 2*W
//   Signals
//     a        multiplicand, sampled with req
//     b        multiplier, sampled with req
//     req      lookup request, accepted on an edge where ready=1
//     rebuild  request to recompute the product table (acted on while serving)
//     ready    high while the table is complete and lookups are accepted
//     valid    one-cycle pulse per accepted request
//     result   product a*b, held between valid pulses
//   Modports
//     master   the consumer issuing lookups
//     slave    the times-table generator
// -----------------------------------------------------------------------------
interface times_table_if #(
  parameter int W = 3
);

  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           req;
  logic           rebuild;
  logic           ready;
  logic           valid;
  logic [2*W-1:0] result;

  modport master (
    output a, b, req, rebuild,
    input  ready, valid, result
  );

  modport slave (
    input  a, b, req, rebuild,
    output ready, valid, result
  );

endinterface

// File: rtl/times_table_gen.sv
// -----------------------------------------------------------------------------
// times_table_gen
//   Small-operand multiplier built as a lookup table. After reset the block
//   fills an internal RAM with every product a*b by repeated addition (there
//   is no multiplier), then serves pipelined lookups: a request accepted at
//   edge E shows valid/result after edge E+1.
//
//   Parameter
//     W        operand width; table depth N = 2**(2*W), result width 2*W
//   Ports
//     clk      sole clock, rising edge
//     rst_n    asynchronous active-low reset (release synchronised externally)
//     bus      times_table_if slave modport (a, b, req, rebuild -> ready,
//              valid, result)
// -----------------------------------------------------------------------------
module times_table_gen #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  times_table_if.slave bus
);

  localparam int AW = 2 * W;     // address width == result width
  localparam int N  = 1 << AW;   // table depth

  typedef enum logic {
    FILL  = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;

  // Fill datapath
  logic [AW-1:0]   idx;          // entry being written this cycle
  logic [AW-1:0]   prod;         // value written at the previous entry
  logic [AW-1:0]   prod_next;    // value written at idx
  logic [W-1:0]    a_i;
  logic [W-1:0]    b_i;

  // Table and lookup pipeline
  logic [AW-1:0]   ram [N];
  logic [AW-1:0]   rd_data;
  logic            s1_valid;
  logic            valid_q;
  logic [AW-1:0]   result_q;

  // FSM-derived controls
  logic            ram_we;
  logic            rd_en;
  logic            restart;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: combinational outputs get a default before any branch so no path
  // leaves them unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      FILL:    if (&idx)       state_next = SERVE;  // last entry written now
      SERVE:   if (bus.rebuild) state_next = FILL;
      default:                  state_next = FILL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and controls
  // ---------------------------------------------------------------------------
  // A request arriving with rebuild is still served: its read happens at the
  // rebuild edge, one edge before the first FILL write.
  always_comb begin
    ram_we  = 1'b0;
    rd_en   = 1'b0;
    restart = 1'b0;
    unique case (state)
      FILL: begin
        ram_we = 1'b1;
      end
      SERVE: begin
        rd_en   = bus.req;
        restart = bus.rebuild;
      end
      default: begin
        ram_we = 1'b0;
      end
    endcase
  end

  assign bus.ready  = (state == SERVE);
  assign bus.valid  = valid_q;
  assign bus.result = result_q;

  // ---------------------------------------------------------------------------
  // Fill datapath: walk {a_i, b_i} with b_i in the LSBs, so along each row
  // the product grows by a_i per step and restarts at 0 when b_i wraps.
  // ---------------------------------------------------------------------------
  assign a_i = idx[AW-1:W];
  assign b_i = idx[W-1:0];

  // (2^W-1)^2 < 2^(2W), so the running sum never overflows AW bits.
  always_comb begin
    prod_next = prod + AW'(a_i);
    if (b_i == '0) begin
      prod_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      prod <= '0;
    end else if (ram_we) begin
      idx  <= idx + AW'(1);      // wraps to 0 after the last entry
      prod <= prod_next;
    end else if (restart) begin
      idx  <= '0;
      prod <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Table RAM: synchronous write during FILL, synchronous read during SERVE.
  // ---------------------------------------------------------------------------
  // NOTE: the RAM and its read register carry no reset; the fill overwrites
  // every entry, and a reset here would prevent mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[idx] <= prod_next;
    end
    if (rd_en) begin
      rd_data <= ram[{bus.a, bus.b}];
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup pipeline: stage 1 tracks the outstanding read, stage 2 presents it.
  // result keeps its value between valid pulses.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      s1_valid <= rd_en;
      valid_q  <= s1_valid;
      if (s1_valid) begin
        result_q <= rd_data;
      end
    end
  end

endmodule
